// File: rtl/pipe_reg_skid.sv
// pipe_reg_skid
//   Generic pipeline stage register with valid/ready handshake. The payload is
//   opaque and is passed through unchanged. It generalises the fixed MEM/WB latch.
//   With SKID_EN=1 a second (skid) entry lets o_ready be decoded purely from state
//   flops, which breaks the combinational ready path to upstream.
//   With SKID_EN=0 the stage holds a single entry and o_ready is combinational.
//
// Ports
//   i_clk        in   1        clock, rising edge
//   i_rst        in   1        asynchronous reset, active-low
//   i_valid      in   1        upstream payload valid
//   o_ready      out  1        stage can accept a payload this cycle
//   i_data       in   DATA_W   upstream payload
//   i_flush      in   1        synchronous flush of held and incoming payloads
//   o_valid      out  1        o_data holds a valid payload
//   i_ready      in   1        downstream accepts the payload
//   o_data       out  DATA_W   payload to the next stage (always the main register)
//   o_count      out  2        number of entries held (0..2)
//   o_stall_cnt  out  CNT_W    saturating count of cycles with o_valid & !i_ready
//
// FSM states
//   state    | meaning
//   ST_EMPTY | nothing held, o_valid=0
//   ST_HALF  | one entry, in main register
//   ST_FULL  | two entries: oldest in main, newest in skid (SKID_EN=1 only)

module pipe_reg_skid #(
  parameter int DATA_W  = 70,
  parameter bit SKID_EN = 1'b1,
  parameter int CNT_W   = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_flush,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic [1:0]        o_count,
  output logic [CNT_W-1:0]  o_stall_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_HALF  = 2'b01,
    ST_FULL  = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t            state;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] skid_q;
  logic              valid_q;
  logic [1:0]        count_q;
  logic [CNT_W-1:0]  stall_q;

  logic xfer_in;
  logic xfer_out;

  // Ready decode. The skid build looks only at the state flops; the single-entry
  // build can accept while draining, which is what gives 1 word/cycle there.
  generate
    if (SKID_EN) begin : g_ready_skid
      assign o_ready = (state != ST_FULL);
    end else begin : g_ready_single
      assign o_ready = (state == ST_EMPTY) | i_ready;
    end
  endgenerate

  assign xfer_in  = i_valid & o_ready;
  assign xfer_out = valid_q & i_ready;

  assign o_valid     = valid_q;
  assign o_data      = main_q;
  assign o_count     = count_q;
  assign o_stall_cnt = stall_q;

  // Handshake FSM. valid_q and count_q are registered alongside the state so
  // they never glitch. A flush only clears the occupancy. The data registers keep
  // stale contents, which are unobservable once valid drops.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state   <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      valid_q <= 1'b0;
      count_q <= 2'd0;
    end else if (i_flush) begin
      state   <= ST_EMPTY;
      valid_q <= 1'b0;
      count_q <= 2'd0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (xfer_in) begin
            state   <= ST_HALF;
            main_q  <= i_data;
            valid_q <= 1'b1;
            count_q <= 2'd1;
          end
        end
        ST_HALF: begin
          if (xfer_in && xfer_out) begin
            main_q <= i_data;
          end else if (xfer_in && SKID_EN) begin
            // Downstream stalled: park the newer word behind the current one.
            state   <= ST_FULL;
            skid_q  <= i_data;
            count_q <= 2'd2;
          end else if (xfer_out) begin
            state   <= ST_EMPTY;
            valid_q <= 1'b0;
            count_q <= 2'd0;
          end
        end
        ST_FULL: begin
          // o_ready is low here, so only a drain can happen.
          if (xfer_out) begin
            state   <= ST_HALF;
            main_q  <= skid_q;
            count_q <= 2'd1;
          end
        end
        default: begin
          state   <= ST_EMPTY;
          valid_q <= 1'b0;
          count_q <= 2'd0;
        end
      endcase
    end
  end

  // Stall counter: reset clears it, flush does not.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      stall_q <= '0;
    end else if (valid_q && !i_ready && (stall_q != CNT_MAX)) begin
      stall_q <= stall_q + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_pipe_reg_skid.sv
module tb_pipe_reg_skid;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // Skid build (SKID_EN=1, CNT_W=4)
  logic       s_valid, s_ready, s_flush, s_oready, s_ovalid;
  logic [7:0] s_data, s_odata;
  logic [1:0] s_count;
  logic [3:0] s_stall;

  // Single-entry build (SKID_EN=0, CNT_W=8)
  logic       n_valid, n_ready, n_flush, n_oready, n_ovalid;
  logic [7:0] n_data, n_odata;
  logic [1:0] n_count;
  logic [7:0] n_stall;

  pipe_reg_skid #(.DATA_W(8), .SKID_EN(1'b1), .CNT_W(4)) u_dut_skid (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_valid     (s_valid),
    .o_ready     (s_oready),
    .i_data      (s_data),
    .i_flush     (s_flush),
    .o_valid     (s_ovalid),
    .i_ready     (s_ready),
    .o_data      (s_odata),
    .o_count     (s_count),
    .o_stall_cnt (s_stall)
  );

  pipe_reg_skid #(.DATA_W(8), .SKID_EN(1'b0), .CNT_W(8)) u_dut_single (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_valid     (n_valid),
    .o_ready     (n_oready),
    .i_data      (n_data),
    .i_flush     (n_flush),
    .o_valid     (n_ovalid),
    .i_ready     (n_ready),
    .o_data      (n_odata),
    .o_count     (n_count),
    .o_stall_cnt (n_stall)
  );

  typedef struct {
    logic       sel;      // 0: skid build, 1: single-entry build
    logic       valid;
    logic [7:0] data;
    logic       ready;
    logic       flush;
    logic       e_valid;
    logic [7:0] e_data;   // compared only when e_valid=1
    logic       e_ready;
    logic [1:0] e_count;
    logic [7:0] e_stall;
  } vec_t;

  localparam int NVEC = 28;
  vec_t vecs [NVEC];

  int n_checks = 0;
  int n_fail   = 0;

  function automatic vec_t mk(input logic sel, input logic v, input logic [7:0] d,
                              input logic r, input logic f, input logic ev,
                              input logic [7:0] ed, input logic er,
                              input logic [1:0] ec, input logic [7:0] es);
    vec_t t;
    t.sel = sel; t.valid = v; t.data = d; t.ready = r; t.flush = f;
    t.e_valid = ev; t.e_data = ed; t.e_ready = er; t.e_count = ec; t.e_stall = es;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_all();
    s_valid = 1'b0; s_data = 8'h00; s_ready = 1'b1; s_flush = 1'b0;
    n_valid = 1'b0; n_data = 8'h00; n_ready = 1'b1; n_flush = 1'b0;
  endtask

  task automatic drive_s(input logic v, input logic [7:0] d, input logic r, input logic f);
    s_valid = v; s_data = d; s_ready = r; s_flush = f;
  endtask

  task automatic drive_n(input logic v, input logic [7:0] d, input logic r, input logic f);
    n_valid = v; n_data = d; n_ready = r; n_flush = f;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    idle_all();
    @(posedge clk);
    #1;
    chk("rst.s_valid", {31'd0, s_ovalid}, 32'd0);
    chk("rst.s_data",  {24'd0, s_odata},  32'd0);
    chk("rst.s_ready", {31'd0, s_oready}, 32'd1);
    chk("rst.s_count", {30'd0, s_count},  32'd0);
    chk("rst.s_stall", {28'd0, s_stall},  32'd0);
    chk("rst.n_valid", {31'd0, n_ovalid}, 32'd0);
    chk("rst.n_ready", {31'd0, n_oready}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    idle_all();

    // Skid build: tests 1-4 plus flush-with-drain and flush-while-empty.
    //                   sel  v  data   r  f    ev edata  er ec     stall
    vecs[0]  = mk(1'b0, 1, 8'h15, 1, 0,   1, 8'h15, 1, 2'd1, 8'd0);
    vecs[1]  = mk(1'b0, 0, 8'h00, 1, 0,   0, 8'h00, 1, 2'd0, 8'd0);
    vecs[2]  = mk(1'b0, 1, 8'h01, 0, 0,   1, 8'h01, 1, 2'd1, 8'd0);
    vecs[3]  = mk(1'b0, 1, 8'h02, 0, 0,   1, 8'h01, 0, 2'd2, 8'd1);
    vecs[4]  = mk(1'b0, 1, 8'h03, 0, 0,   1, 8'h01, 0, 2'd2, 8'd2);
    vecs[5]  = mk(1'b0, 1, 8'h03, 1, 0,   1, 8'h02, 1, 2'd1, 8'd2);
    vecs[6]  = mk(1'b0, 1, 8'h03, 1, 0,   1, 8'h03, 1, 2'd1, 8'd2);
    vecs[7]  = mk(1'b0, 0, 8'h00, 1, 0,   0, 8'h00, 1, 2'd0, 8'd2);
    vecs[8]  = mk(1'b0, 1, 8'h0A, 0, 0,   1, 8'h0A, 1, 2'd1, 8'd2);
    vecs[9]  = mk(1'b0, 1, 8'h0B, 0, 0,   1, 8'h0A, 0, 2'd2, 8'd3);
    vecs[10] = mk(1'b0, 1, 8'hAA, 0, 1,   0, 8'h00, 1, 2'd0, 8'd4);
    vecs[11] = mk(1'b0, 0, 8'h00, 1, 0,   0, 8'h00, 1, 2'd0, 8'd4);
    vecs[12] = mk(1'b0, 1, 8'h0C, 1, 0,   1, 8'h0C, 1, 2'd1, 8'd4);
    vecs[13] = mk(1'b0, 0, 8'h00, 1, 0,   0, 8'h00, 1, 2'd0, 8'd4);
    vecs[14] = mk(1'b0, 1, 8'h0D, 0, 0,   1, 8'h0D, 1, 2'd1, 8'd4);
    vecs[15] = mk(1'b0, 1, 8'h0E, 1, 1,   0, 8'h00, 1, 2'd0, 8'd4);
    vecs[16] = mk(1'b0, 0, 8'h00, 0, 0,   0, 8'h00, 1, 2'd0, 8'd4);
    vecs[17] = mk(1'b0, 1, 8'h0F, 1, 1,   0, 8'h00, 1, 2'd0, 8'd4);
    vecs[18] = mk(1'b0, 1, 8'h10, 0, 0,   1, 8'h10, 1, 2'd1, 8'd4);
    // Single-entry build: combinational ready, never two entries.
    vecs[19] = mk(1'b1, 1, 8'h21, 1, 0,   1, 8'h21, 1, 2'd1, 8'd0);
    vecs[20] = mk(1'b1, 1, 8'h22, 1, 0,   1, 8'h22, 1, 2'd1, 8'd0);
    vecs[21] = mk(1'b1, 1, 8'h23, 1, 0,   1, 8'h23, 1, 2'd1, 8'd0);
    vecs[22] = mk(1'b1, 1, 8'h24, 0, 0,   1, 8'h23, 0, 2'd1, 8'd1);
    vecs[23] = mk(1'b1, 1, 8'h24, 1, 0,   1, 8'h24, 1, 2'd1, 8'd1);
    vecs[24] = mk(1'b1, 0, 8'h00, 1, 0,   0, 8'h00, 1, 2'd0, 8'd1);
    vecs[25] = mk(1'b1, 0, 8'h00, 0, 0,   0, 8'h00, 1, 2'd0, 8'd1);
    vecs[26] = mk(1'b1, 1, 8'h25, 0, 0,   1, 8'h25, 0, 2'd1, 8'd1);
    vecs[27] = mk(1'b1, 1, 8'h26, 0, 1,   0, 8'h00, 1, 2'd0, 8'd2);

    do_reset();

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      idle_all();
      if (vecs[i].sel == 1'b0)
        drive_s(vecs[i].valid, vecs[i].data, vecs[i].ready, vecs[i].flush);
      else
        drive_n(vecs[i].valid, vecs[i].data, vecs[i].ready, vecs[i].flush);
      @(posedge clk);
      #1;
      if (vecs[i].sel == 1'b0) begin
        chk($sformatf("vec%0d.o_valid", i), {31'd0, s_ovalid}, {31'd0, vecs[i].e_valid});
        chk($sformatf("vec%0d.o_ready", i), {31'd0, s_oready}, {31'd0, vecs[i].e_ready});
        chk($sformatf("vec%0d.o_count", i), {30'd0, s_count},  {30'd0, vecs[i].e_count});
        chk($sformatf("vec%0d.o_stall", i), {28'd0, s_stall},  {24'd0, vecs[i].e_stall});
        if (vecs[i].e_valid)
          chk($sformatf("vec%0d.o_data", i), {24'd0, s_odata}, {24'd0, vecs[i].e_data});
      end else begin
        chk($sformatf("vec%0d.o_valid", i), {31'd0, n_ovalid}, {31'd0, vecs[i].e_valid});
        chk($sformatf("vec%0d.o_ready", i), {31'd0, n_oready}, {31'd0, vecs[i].e_ready});
        chk($sformatf("vec%0d.o_count", i), {30'd0, n_count},  {30'd0, vecs[i].e_count});
        chk($sformatf("vec%0d.o_stall", i), {24'd0, n_stall},  {24'd0, vecs[i].e_stall});
        if (vecs[i].e_valid)
          chk($sformatf("vec%0d.o_data", i), {24'd0, n_odata}, {24'd0, vecs[i].e_data});
      end
    end

    // Single-entry build: continuous stream at i_ready=1 moves one word per cycle.
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      drive_n(1'b1, 8'h40 + 8'(k), 1'b1, 1'b0);
      @(posedge clk);
      #1;
      chk($sformatf("stream%0d.o_valid", k), {31'd0, n_ovalid}, 32'd1);
      chk($sformatf("stream%0d.o_data", k),  {24'd0, n_odata},  32'h40 + 32'(k));
      chk($sformatf("stream%0d.o_ready", k), {31'd0, n_oready}, 32'd1);
    end
    @(negedge clk);
    drive_n(1'b0, 8'h00, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    chk("stream.drain_valid", {31'd0, n_ovalid}, 32'd0);
    chk("stream.stall_cnt",   {24'd0, n_stall},  32'd2);

    // Stall counter saturation on the 4-bit counter; flush must not clear it.
    do_reset();
    @(negedge clk);
    drive_s(1'b1, 8'h5A, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("sat.load_valid", {31'd0, s_ovalid}, 32'd1);
    chk("sat.start",      {28'd0, s_stall},  32'd0);
    @(negedge clk);
    drive_s(1'b0, 8'h00, 1'b0, 1'b0);
    repeat (14) @(posedge clk);
    #1;
    chk("sat.at14", {28'd0, s_stall}, 32'd14);
    @(posedge clk);
    #1;
    chk("sat.at15", {28'd0, s_stall}, 32'd15);
    repeat (5) @(posedge clk);
    #1;
    chk("sat.hold", {28'd0, s_stall}, 32'd15);
    chk("sat.data", {24'd0, s_odata}, 32'h5A);
    @(negedge clk);
    drive_s(1'b1, 8'hAA, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    chk("sat.flush_valid", {31'd0, s_ovalid}, 32'd0);
    chk("sat.flush_count", {30'd0, s_count},  32'd0);
    chk("sat.flush_stall", {28'd0, s_stall},  32'd15);
    @(negedge clk);
    drive_s(1'b0, 8'h00, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("sat.after_flush", {28'd0, s_stall}, 32'd15);

    // Asynchronous reset asserted between clock edges.
    @(negedge clk);
    drive_s(1'b1, 8'h33, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("arst.pre_valid", {31'd0, s_ovalid}, 32'd1);
    chk("arst.pre_data",  {24'd0, s_odata},  32'h33);
    #2;
    rst = 1'b0;
    #1;
    chk("arst.valid", {31'd0, s_ovalid}, 32'd0);
    chk("arst.count", {30'd0, s_count},  32'd0);
    chk("arst.ready", {31'd0, s_oready}, 32'd1);
    chk("arst.stall", {28'd0, s_stall},  32'd0);
    chk("arst.data",  {24'd0, s_odata},  32'd0);
    @(posedge clk);
    #1;
    chk("arst.no_capture", {31'd0, s_ovalid}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    drive_s(1'b0, 8'h00, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    chk("arst.released_empty", {31'd0, s_ovalid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
